// File: rtl/ofm_pack_1x1.sv
// ---------------------------------------------------------------------------
// ofm_pack_1x1
//   Output stage of the 1x1 PE cluster. Each of the four PEs delivers an 8-bit
//   OFM result on its own lane, with its own one-cycle valid pulse. Results are
//   held per lane until all four lanes are present. The four lanes are then
//   packed into one 32-bit word, tagged with a sequential write address, and
//   pushed into a small first-word-fall-through FIFO. The OFM buffer drains the
//   FIFO over a valid/ready handshake.
//
//   Build option OFM_RELU_EN: when defined, each lane value is clamped at
//   capture (negative -> 0). Otherwise lanes are stored raw. Addressing,
//   handshake and timing are the same in both builds.
//
// Parameters
//   FIFO_DEPTH  packed-word FIFO entries (power of 2, >= 2)
//   ADDR_W      width of the OFM write address counter (wraps)
//
// Ports
//   clk        clock, all state updates on the rising edge
//   reset_n    asynchronous active-low reset
//   clear      synchronous layer-start clear (FIFO, lanes, address, err)
//   OFM_0..3   per-PE signed int8 results, lane i = OFM_i
//   valid_in   valid_in[i] pulses while OFM_i carries a result
//   ofm_data   {lane3,lane2,lane1,lane0} of the FIFO head
//   ofm_addr   write address of the FIFO head
//   ofm_valid  FIFO holds at least one word
//   ofm_ready  consumer takes the head when ofm_valid & ofm_ready
//   stall      FIFO full; the controller must hold off the next PE_finish
//   err        sticky lane-overrun flag
// ---------------------------------------------------------------------------
module ofm_pack_1x1 #(
    parameter int FIFO_DEPTH = 4,
    parameter int ADDR_W     = 16
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              clear,
    input  logic [7:0]        OFM_0,
    input  logic [7:0]        OFM_1,
    input  logic [7:0]        OFM_2,
    input  logic [7:0]        OFM_3,
    input  logic [3:0]        valid_in,
    output logic [31:0]       ofm_data,
    output logic [ADDR_W-1:0] ofm_addr,
    output logic              ofm_valid,
    input  logic              ofm_ready,
    output logic              stall,
    output logic              err
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    // Lane clamp applied at capture time.
    function automatic logic [7:0] lane_clamp(input logic signed [7:0] v);
`ifdef OFM_RELU_EN
        lane_clamp = (v < 0) ? 8'h00 : v;
`else
        lane_clamp = v;
`endif
    endfunction

    logic [7:0]        ofm_in   [4];
    logic [7:0]        cap_val  [4];
    logic [7:0]        lane_data[4];
    logic [3:0]        got;

    logic [31:0]       mem_data [FIFO_DEPTH];
    logic [ADDR_W-1:0] mem_addr [FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [CNT_W-1:0]  count;
    logic [CNT_W-1:0]  count_nxt;
    logic [ADDR_W-1:0] addr_cnt;
    logic [31:0]       last_data;
    logic [ADDR_W-1:0] last_addr;

    logic              all_got;
    logic              fifo_full;
    logic              push;
    logic              pop;
    logic [31:0]       push_word;

    assign ofm_in[0] = OFM_0;
    assign ofm_in[1] = OFM_1;
    assign ofm_in[2] = OFM_2;
    assign ofm_in[3] = OFM_3;

    // A lane already holding a result contributes its stored value; a lane
    // arriving this cycle contributes its live input, so the word can be
    // pushed in the same cycle the last lane shows up.
    always_comb begin
        push_word = '0;
        for (int i = 0; i < 4; i++) begin
            cap_val[i]            = lane_clamp(ofm_in[i]);
            push_word[8*i +: 8]   = got[i] ? lane_data[i] : cap_val[i];
        end
    end

    assign all_got   = &(got | valid_in);
    assign fifo_full = (count == CNT_W'(FIFO_DEPTH));
    assign ofm_valid = (count != '0);
    // clear overrides both handshake directions in its cycle.
    assign pop       = ofm_valid & ofm_ready & ~clear;
    // A pop at full frees the slot the push needs in the same cycle.
    assign push      = all_got & (~fifo_full | pop) & ~clear;

    always_comb begin
        count_nxt = count;
        case ({push, pop})
            2'b10:   count_nxt = count + CNT_W'(1);
            2'b01:   count_nxt = count - CNT_W'(1);
            default: count_nxt = count;
        endcase
    end

    // Head view: the live FIFO head, or the last word handed out once empty.
    assign ofm_data = ofm_valid ? mem_data[rd_ptr] : last_data;
    assign ofm_addr = ofm_valid ? mem_addr[rd_ptr] : last_addr;

    // Control state: lane occupancy, FIFO pointers, address, flags.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            got       <= '0;
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            addr_cnt  <= '0;
            last_data <= '0;
            last_addr <= '0;
            stall     <= 1'b0;
            err       <= 1'b0;
        end else if (clear) begin
            got       <= '0;
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            addr_cnt  <= '0;
            last_data <= '0;
            last_addr <= '0;
            stall     <= 1'b0;
            err       <= 1'b0;
        end else begin
            count <= count_nxt;
            stall <= (count_nxt == CNT_W'(FIFO_DEPTH));
            if (push) begin
                wr_ptr   <= wr_ptr + PTR_W'(1);
                addr_cnt <= addr_cnt + ADDR_W'(1);
                // Arrivals on lanes that were already full start the next word.
                got      <= got & valid_in;
            end else begin
                got <= got | valid_in;
                if (|(got & valid_in))
                    err <= 1'b1;
            end
            if (pop) begin
                rd_ptr    <= rd_ptr + PTR_W'(1);
                last_data <= mem_data[rd_ptr];
                last_addr <= mem_addr[rd_ptr];
            end
        end
    end

    // Datapath storage: lane holding registers and FIFO array.
    always_ff @(posedge clk) begin
        for (int i = 0; i < 4; i++) begin
            // An overrun (lane full, no push) keeps the first value.
            if (valid_in[i] && (!got[i] || push))
                lane_data[i] <= cap_val[i];
        end
        if (push) begin
            mem_data[wr_ptr] <= push_word;
            mem_addr[wr_ptr] <= addr_cnt;
        end
    end

endmodule

// File: tb/tb_ofm_pack_1x1.sv
module tb_ofm_pack_1x1;

    logic        clk;
    logic        reset_n;
    logic        clear;
    logic [7:0]  OFM_0, OFM_1, OFM_2, OFM_3;
    logic [3:0]  valid_in;
    logic [31:0] ofm_data;
    logic [15:0] ofm_addr;
    logic        ofm_valid;
    logic        ofm_ready;
    logic        stall;
    logic        err;

    int checks   = 0;
    int failures = 0;

    ofm_pack_1x1 #(.FIFO_DEPTH(4), .ADDR_W(16)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .clear     (clear),
        .OFM_0     (OFM_0),
        .OFM_1     (OFM_1),
        .OFM_2     (OFM_2),
        .OFM_3     (OFM_3),
        .valid_in  (valid_in),
        .ofm_data  (ofm_data),
        .ofm_addr  (ofm_addr),
        .ofm_valid (ofm_valid),
        .ofm_ready (ofm_ready),
        .stall     (stall),
        .err       (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Advance one clock; sample point is 1 time unit after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
        valid_in = 4'h0;
        clear    = 1'b0;
    endtask

    task automatic setv(input logic [3:0] v, input logic [7:0] a, input logic [7:0] b,
                        input logic [7:0] c, input logic [7:0] d);
        valid_in = v;
        OFM_0 = a; OFM_1 = b; OFM_2 = c; OFM_3 = d;
    endtask

    function automatic logic [31:0] t2_word(input int j);
        logic [7:0] base;
        base = 8'(16 * j);
        return {base + 8'd3, base + 8'd2, base + 8'd1, base};
    endfunction

    initial begin
        reset_n = 1'b0; clear = 1'b0; ofm_ready = 1'b0;
        setv(4'h0, 8'h0, 8'h0, 8'h0, 8'h0);
        tick(); tick();
        chk("rst_valid", ofm_valid, 1'b0);
        chk("rst_data",  ofm_data,  32'h0);
        chk("rst_addr",  ofm_addr,  16'h0);
        chk("rst_stall", stall,     1'b0);
        chk("rst_err",   err,       1'b0);
        reset_n = 1'b1;
        tick();

        // Lanes arriving one per cycle
        setv(4'b0001, 8'd11, 8'd0, 8'd0, 8'd0); tick();
        setv(4'b0010, 8'd0, 8'd22, 8'd0, 8'd0); tick();
        setv(4'b0100, 8'd0, 8'd0, 8'd33, 8'd0); tick();
        chk("t1_partial_valid", ofm_valid, 1'b0);
        setv(4'b1000, 8'd0, 8'd0, 8'd0, 8'd44); tick();
        chk("t1_valid", ofm_valid, 1'b1);
        chk("t1_data",  ofm_data,  32'h2C21160B);
        chk("t1_addr",  ofm_addr,  16'h0);
        ofm_ready = 1'b1;
        tick();
        chk("t1_pop_valid", ofm_valid, 1'b0);
        chk("t1_hold_data", ofm_data,  32'h2C21160B);

        // Back-to-back full words with a ready consumer
        clear = 1'b1; tick();
        chk("t2_clear_valid", ofm_valid, 1'b0);
        for (int j = 0; j < 6; j++) begin
            logic [31:0] w;
            w = t2_word(j);
            setv(4'hF, w[7:0], w[15:8], w[23:16], w[31:24]);
            tick();
            chk($sformatf("t2_valid%0d", j), ofm_valid, 1'b1);
            chk($sformatf("t2_addr%0d", j),  ofm_addr,  64'(j));
            chk($sformatf("t2_data%0d", j),  ofm_data,  t2_word(j));
            chk($sformatf("t2_stall%0d", j), stall,     1'b0);
        end
        tick();
        chk("t2_drained", ofm_valid, 1'b0);

        // Fill to full, hold a fifth word, then drain
        clear = 1'b1; ofm_ready = 1'b0; tick();
        for (int j = 0; j < 4; j++) begin
            setv(4'hF, 8'h40 + 8'(j), 8'h41, 8'h42, 8'h43);
            tick();
        end
        chk("t3_stall_full", stall,    1'b1);
        chk("t3_head_addr0", ofm_addr, 16'd0);
        setv(4'hF, 8'h51, 8'h52, 8'h53, 8'h54); tick();
        chk("t3_hold_stall", stall,    1'b1);
        chk("t3_hold_head",  ofm_addr, 16'd0);
        chk("t3_hold_err",   err,      1'b0);
        ofm_ready = 1'b1; tick();
        chk("t3_swap_stall", stall,    1'b1);
        chk("t3_head_addr1", ofm_addr, 16'd1);
        chk("t3_head_data1", ofm_data, 32'h43424141);
        tick();
        chk("t3_head_addr2", ofm_addr, 16'd2);
        chk("t3_stall_low",  stall,    1'b0);
        tick();
        chk("t3_head_addr3", ofm_addr, 16'd3);
        tick();
        chk("t3_head_addr4", ofm_addr, 16'd4);
        chk("t3_head_data4", ofm_data, 32'h54535251);
        tick();
        chk("t3_empty", ofm_valid, 1'b0);

        // Lane overrun, then clear
        clear = 1'b1; tick();
        setv(4'b0010, 8'h0, 8'h12, 8'h0, 8'h0); tick();
        chk("t4_no_err_yet", err, 1'b0);
        setv(4'b0010, 8'h0, 8'h99, 8'h0, 8'h0); tick();
        chk("t4_err_set", err, 1'b1);
        setv(4'b1101, 8'h01, 8'h0, 8'h03, 8'h04); tick();
        chk("t4_first_kept", ofm_data, 32'h04031201);
        chk("t4_err_sticky", err,      1'b1);
        clear = 1'b1; tick();
        chk("t4_clr_err",   err,       1'b0);
        chk("t4_clr_valid", ofm_valid, 1'b0);
        chk("t4_clr_addr",  ofm_addr,  16'h0);
        chk("t4_clr_data",  ofm_data,  32'h0);
        setv(4'hF, 8'h61, 8'h62, 8'h63, 8'h64); tick();
        chk("t4_addr_restart", ofm_addr, 16'h0);

        // Arrival on a full lane in the push cycle belongs to the next word
        setv(4'b0111, 8'h21, 8'h22, 8'h23, 8'h0); tick();
        setv(4'b1001, 8'h7F, 8'h0, 8'h0, 8'h24); tick();
        chk("t5_word_a", ofm_data, 32'h24232221);
        chk("t5_addr_a", ofm_addr, 16'd1);
        chk("t5_err_a",  err,      1'b0);
        setv(4'b1110, 8'h0, 8'h31, 8'h32, 8'h33); tick();
        chk("t5_word_b", ofm_data, 32'h3332317F);
        chk("t5_addr_b", ofm_addr, 16'd2);
        chk("t5_err_b",  err,      1'b0);

        // Negative lane handling
        setv(4'hF, 8'h80, 8'hFF, 8'h01, 8'h7F); tick();
`ifdef OFM_RELU_EN
        chk("t6_relu", ofm_data, 32'h7F010000);
`else
        chk("t6_raw",  ofm_data, 32'h7F01FF80);
`endif
        tick();

        // Asynchronous reset discards FIFO contents and partial lanes
        ofm_ready = 1'b0;
        setv(4'hF, 8'h1, 8'h2, 8'h3, 8'h4); tick();
        setv(4'b0011, 8'h5, 8'h6, 8'h0, 8'h0); tick();
        chk("t7_pre_valid", ofm_valid, 1'b1);
        reset_n = 1'b0;
        #1;
        chk("t7_async_valid", ofm_valid, 1'b0);
        chk("t7_async_data",  ofm_data,  32'h0);
        tick();
        reset_n = 1'b1;
        tick();
        setv(4'b1100, 8'h0, 8'h0, 8'h7, 8'h8); tick();
        chk("t7_lanes_dropped", ofm_valid, 1'b0);
        tick();
        chk("t7_still_empty", ofm_valid, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
